light_sweep_scheduler: RTL and testbench
========================================

LIGHT_SWEEP_SCHEDULER -- requirements
Module: light_sweep_scheduler

Interface
REQ-001 SHALL have parameter INSTRUCTION_WIDTH, default 50, giving the width of the command word: {op[49:48], start_row[47:36], start_col[35:24], end_row[23:12], end_col[11:0]}.
REQ-002 SHALL have parameter ROWS, default 1000, giving the number of display rows.
REQ-003 SHALL have parameter LATENCY, default 3, giving the number of cycles from read address to write of the same row; legal range 2..8.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, giving the number of command buffer entries; power of two, at least 2.
REQ-005 SHALL have ports, in this order:
clk  in  1  sole clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
instr_last  in  1  marks the final command.
instr_valid  in  1  command word valid.
instr_ready  out  1  command accepted when valid and ready are both high.
instr_data  in  INSTRUCTION_WIDTH  command word.
rd_en  out  1  datapath row read strobe.
rd_addr  out  $clog2(ROWS)  read row.
wr_en  out  1  datapath row write strobe.
wr_addr  out  $clog2(ROWS)  write row.
cmd_op  out  2  operation of the active command.
cmd_col_start  out  12  start column of the active command.
cmd_col_end  out  12  end column of the active command.
sum_en  out  1  intensity-sum sweep read strobe.
sum_done  out  1  sum sweep complete.
busy  out  1  scheduler not in IDLE or DONE.
cmd_error  out  1  sticky flag for a dropped command.
cmd_count  out  16  accepted-command counter.
busy_cycles  out  32  busy cycle counter.

Function
REQ-006 SHALL accept commands into a FIFO_DEPTH-entry FIFO; instr_ready = !fifo_full && !last_seen, registered-equivalent with no combinational path from instr_valid.
REQ-007 SHALL set last_seen on the handshake carrying instr_last; further commands are refused until reset.
REQ-008 SHALL implement states IDLE, LOAD, SWEEP, DRAIN, SUM, SUM_DRAIN, DONE.
REQ-009 SHALL transition IDLE->LOAD when the FIFO is non-empty, and IDLE->SUM when the FIFO is empty and last_seen is set.
REQ-010 In LOAD, SHALL pop one entry and latch op/columns/rows into cmd_* registers held stable until the next LOAD.
REQ-011 SHALL drop a command if start_row>end_row or end_row>=ROWS, set cmd_error, and return to IDLE without asserting rd_en.
REQ-012 Otherwise SHALL go LOAD->SWEEP, asserting rd_en with rd_addr = start_row..end_row, one row per cycle, contiguous, with end_row-start_row+1 strobes.
REQ-013 SHALL produce wr_en/wr_addr as rd_en/rd_addr delayed by exactly LATENCY-1 cycles through a shift register.
REQ-014 After the last read, SHALL go SWEEP->DRAIN and stay until the write pipeline is empty (LATENCY-1 cycles); on leaving DRAIN, the next rd_en SHALL NOT precede the last wr_en.
REQ-015 On leaving DRAIN, SHALL go to LOAD if the FIFO is non-empty, else to SUM if last_seen is set, else to IDLE.
REQ-016 In SUM, SHALL assert rd_en and sum_en with rd_addr 0..ROWS-1 over ROWS cycles; wr_en SHALL stay low.
REQ-017 SHALL go SUM->SUM_DRAIN for LATENCY cycles, then enter DONE, where sum_done=1 is held until reset.
REQ-018 A FIFO push and pop in the same cycle SHALL be legal when the FIFO is full or empty-at-pop-time rules permit; occupancy is unchanged.
REQ-019 An instr_last arriving while a sweep is active SHALL be honoured after the FIFO drains.

Reset
REQ-020 On reset_n low, asynchronously: state=IDLE, FIFO empty, last_seen=0; all outputs 0 except instr_ready, which becomes 1 on the first clk edge after release.
REQ-021 Reset assertion mid-sweep SHALL abort the sweep with no further rd_en/wr_en; the pipeline is cleared.

Configuration
REQ-022 Macro LIGHT_SWEEP_STATS_EN defined: cmd_count increments per accepted handshake (saturating at 0xFFFF) and busy_cycles increments each cycle busy=1 (wrapping).
REQ-023 LIGHT_SWEEP_STATS_EN undefined: cmd_count and busy_cycles are constant 0, and no counter registers are inferred.

Verification
REQ-024 One command with rows 5..7, instr_last=1, LATENCY=3 -> rd_en for 3 cycles at rows 5,6,7; wr_en 2 cycles later at rows 5,6,7; then a 1000-cycle sum sweep, and sum_done=1.
REQ-025 Push 5 commands back-to-back with FIFO_DEPTH=4 while the first sweeps -> instr_ready drops when full; all 5 execute in order and no read overlaps a prior command's writes.
REQ-026 Command start_row=10, end_row=4 -> no rd_en and cmd_error=1; the following valid command executes normally.
REQ-027 Command with end_row=1000 (ROWS=1000) -> dropped and cmd_error=1.
REQ-028 reset_n low for one cycle during row 300 of a 0..999 sweep -> outputs go 0 immediately, FIFO empty, instr_ready=1 after release.
REQ-029 LIGHT_SWEEP_STATS_EN defined, 3 commands each covering rows 0..0 -> cmd_count=3 and busy_cycles matches the simulated count; macro undefined -> both read 0.

Source files
------------

// File: rtl/light_sweep_scheduler.sv
// light_sweep_scheduler
// Buffers row-sweep commands in a small FIFO and sequences a datapath:
// each command reads rows start_row..end_row, the matching writes follow
// LATENCY-1 cycles later, and after the final command a full-frame
// intensity-sum read sweep runs before DONE.
// Optional build macro LIGHT_SWEEP_STATS_EN enables the cmd_count and
// busy_cycles statistics counters; without it both outputs are tied to 0.
module light_sweep_scheduler #(
  parameter int INSTRUCTION_WIDTH = 50,
  parameter int ROWS              = 1000,
  parameter int LATENCY           = 3,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         instr_last,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_data,
  output logic                         rd_en,
  output logic [$clog2(ROWS)-1:0]      rd_addr,
  output logic                         wr_en,
  output logic [$clog2(ROWS)-1:0]      wr_addr,
  output logic [1:0]                   cmd_op,
  output logic [11:0]                  cmd_col_start,
  output logic [11:0]                  cmd_col_end,
  output logic                         sum_en,
  output logic                         sum_done,
  output logic                         busy,
  output logic                         cmd_error,
  output logic [15:0]                  cmd_count,
  output logic [31:0]                  busy_cycles
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int PIPE  = LATENCY - 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SWEEP, S_DRAIN, S_SUM, S_SUM_DRAIN, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [INSTRUCTION_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   fifo_cnt_q;
  logic             fifo_full, fifo_empty;
  logic             last_seen_q, ready_en_q;
  logic             push, pop;

  logic [INSTRUCTION_WIDTH-1:0] head;
  logic [11:0]      head_start, head_end;
  logic             head_bad;

  logic [ROW_W-1:0] row_q, end_q;
  logic [2:0]       drain_q;

  logic             vld_p  [PIPE];
  logic [ROW_W-1:0] addr_p [PIPE];

  assign fifo_full   = (fifo_cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty  = (fifo_cnt_q == '0);
  // Ready depends only on registered state; it stays low until the first edge after reset.
  assign instr_ready = ready_en_q && !fifo_full && !last_seen_q;
  assign push        = instr_valid && instr_ready;
  assign pop         = (state_q == S_LOAD);

  assign head       = fifo_mem[rd_ptr_q];
  assign head_start = head[47:36];
  assign head_end   = head[23:12];
  assign head_bad   = (head_start > head_end) || (32'(head_end) >= 32'(ROWS));

  // FIFO pointers, occupancy, last-command latch and post-reset ready enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      last_seen_q <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fifo_cnt_q <= fifo_cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      if (push && instr_last) last_seen_q <= 1'b1;
    end
  end

  // FIFO storage carries data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= instr_data;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d  = state_q;
    rd_en    = 1'b0;
    sum_en   = 1'b0;
    sum_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty)      state_d = S_LOAD;
        else if (last_seen_q) state_d = S_SUM;
      end
      S_LOAD: state_d = head_bad ? S_IDLE : S_SWEEP;
      S_SWEEP: begin
        rd_en = 1'b1;
        if (row_q == end_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_q == 3'(LATENCY - 2)) begin
          if (!fifo_empty)      state_d = S_LOAD;
          else if (last_seen_q) state_d = S_SUM;
          else                  state_d = S_IDLE;
        end
      end
      S_SUM: begin
        rd_en  = 1'b1;
        sum_en = 1'b1;
        if (row_q == LAST_ROW) state_d = S_SUM_DRAIN;
      end
      S_SUM_DRAIN: begin
        if (drain_q == 3'(LATENCY - 1)) state_d = S_DONE;
      end
      S_DONE:  sum_done = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign rd_addr = rd_en ? row_q : '0;

  // Command latch, row/drain counters and sticky drop flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q         <= '0;
      end_q         <= '0;
      drain_q       <= '0;
      cmd_op        <= '0;
      cmd_col_start <= '0;
      cmd_col_end   <= '0;
      cmd_error     <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          row_q         <= head_start[ROW_W-1:0];
          end_q         <= head_end[ROW_W-1:0];
          cmd_op        <= head[49:48];
          cmd_col_start <= head[35:24];
          cmd_col_end   <= head[11:0];
          if (head_bad) cmd_error <= 1'b1;
        end
        S_SWEEP, S_SUM:        row_q   <= row_q + ROW_W'(1);
        S_DRAIN, S_SUM_DRAIN:  drain_q <= drain_q + 3'd1;
        default: ;
      endcase
      if (state_d != state_q) begin
        drain_q <= '0;
        if (state_d == S_SUM) row_q <= '0;
      end
    end
  end

  // ---- write pipeline: valid stages (control, reset) ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= (state_q == S_SWEEP);
      for (int i = 1; i < PIPE; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // ---- write pipeline: address stages (data, no reset) ----
  always_ff @(posedge clk) begin
    addr_p[0] <= row_q;
    for (int i = 1; i < PIPE; i++) addr_p[i] <= addr_p[i-1];
  end

  assign wr_en   = vld_p[PIPE-1];
  assign wr_addr = wr_en ? addr_p[PIPE-1] : '0;

`ifdef LIGHT_SWEEP_STATS_EN
  logic [15:0] cmd_count_q;
  logic [31:0] busy_cycles_q;

  // Accepted-command counter (saturating) and busy-cycle counter (wrapping).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_count_q   <= '0;
      busy_cycles_q <= '0;
    end else begin
      if (push && (cmd_count_q != 16'hFFFF)) cmd_count_q <= cmd_count_q + 16'd1;
      if (busy) busy_cycles_q <= busy_cycles_q + 32'd1;
    end
  end

  assign cmd_count   = cmd_count_q;
  assign busy_cycles = busy_cycles_q;
`else
  assign cmd_count   = '0;
  assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_light_sweep_scheduler.sv
// Directed bench for light_sweep_scheduler (default parameters:
// ROWS=1000, LATENCY=3, FIFO_DEPTH=4). A negedge monitor records read,
// write and sum strobes; a queue of outstanding reads is the write model.
module tb_light_sweep_scheduler;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        instr_last = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [49:0] instr_data = '0;
  logic        rd_en, wr_en, sum_en, sum_done, busy, cmd_error;
  logic [9:0]  rd_addr, wr_addr;
  logic [1:0]  cmd_op;
  logic [11:0] cmd_col_start, cmd_col_end;
  logic [15:0] cmd_count;
  logic [31:0] busy_cycles;

  light_sweep_scheduler dut (
    .clk(clk), .reset_n(reset_n), .instr_last(instr_last),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .cmd_op(cmd_op),
    .cmd_col_start(cmd_col_start), .cmd_col_end(cmd_col_end),
    .sum_en(sum_en), .sum_done(sum_done), .busy(busy),
    .cmd_error(cmd_error), .cmd_count(cmd_count), .busy_cycles(busy_cycles)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Monitor state (written only by the monitor process).
  int epoch = 0, seen_epoch = 0;
  int rd_n = 0, wr_n = 0, sum_n = 0, busy_n = 0;
  int rd_first = 0, rd_last = 0, wr_last = 0, sum_first = 0, sum_last = 0;
  int rd_first_cyc = 0, wr_first_cyc = 0;
  int contig_err = 0, sum_contig = 0, gap_viol = 0, wr_mis = 0, wr_in_sum = 0;
  logic prev_rd = 1'b0;
  int pend[$];
  int bursts[$];

  always @(negedge clk) begin
    if (!reset_n) begin
      pend.delete();
      busy_n  = 0;
      prev_rd = 1'b0;
    end else begin
      if (epoch != seen_epoch) begin
        seen_epoch = epoch;
        rd_n = 0; wr_n = 0; sum_n = 0; contig_err = 0; sum_contig = 0;
        gap_viol = 0; wr_mis = 0; wr_in_sum = 0;
        bursts.delete();
      end
      if (busy) busy_n++;
      if (wr_en) begin
        if (wr_n == 0) wr_first_cyc = cyc;
        wr_last = int'(wr_addr);
        wr_n++;
        if (pend.size() == 0) wr_mis++;
        else begin
          if (pend[0] != int'(wr_addr)) wr_mis++;
          void'(pend.pop_front());
        end
        if (sum_en) wr_in_sum++;
      end
      if (rd_en && !sum_en) begin
        if (!prev_rd) begin
          bursts.push_back(int'(rd_addr));
          if (pend.size() != 0) gap_viol++;
        end else if (int'(rd_addr) != rd_last + 1) contig_err++;
        if (rd_n == 0) begin
          rd_first     = int'(rd_addr);
          rd_first_cyc = cyc;
        end
        rd_last = int'(rd_addr);
        rd_n++;
        pend.push_back(int'(rd_addr));
      end
      if (rd_en && sum_en) begin
        if (sum_n == 0) sum_first = int'(rd_addr);
        else if (int'(rd_addr) != sum_last + 1) sum_contig++;
        sum_last = int'(rd_addr);
        sum_n++;
      end
      prev_rd = rd_en && !sum_en;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] s, input logic [11:0] e,
                      input logic [11:0] cs, input logic [11:0] ce,
                      input logic [1:0] op, input logic last);
    int k;
    instr_data  = {op, s, cs, e, ce};
    instr_valid = 1'b1;
    instr_last  = last;
    k = 0;
    while (!instr_ready && k < 5000) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 5000) check("send_timeout", 64'd1, 64'd0);
    else begin
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    instr_last  = 1'b0;
  endtask

  task automatic wait_sum_done(input int limit);
    int k;
    k = 0;
    while (!sum_done && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("sum_done_reached", sum_done, 1);
  endtask

  typedef struct {
    logic [11:0] s, e, cs, ce;
    logic [1:0]  op;
    int          exp_n;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];
  int   exp_bursts[6] = '{20, 30, 40, 50, 60, 70};

  initial begin
    vecs[0] = '{s:12'd5,   e:12'd7,    cs:12'd100, ce:12'd200,  op:2'd1, exp_n:3, exp_err:1'b0};
    vecs[1] = '{s:12'd10,  e:12'd4,    cs:12'd1,   ce:12'd2,    op:2'd2, exp_n:0, exp_err:1'b1};
    vecs[2] = '{s:12'd4,   e:12'd4,    cs:12'd7,   ce:12'd8,    op:2'd3, exp_n:1, exp_err:1'b1};
    vecs[3] = '{s:12'd0,   e:12'd1000, cs:12'd0,   ce:12'd0,    op:2'd0, exp_n:0, exp_err:1'b1};
    vecs[4] = '{s:12'd998, e:12'd999,  cs:12'd0,   ce:12'd4095, op:2'd2, exp_n:2, exp_err:1'b1};
    vecs[5] = '{s:12'd999, e:12'd999,  cs:12'd33,  ce:12'd44,   op:2'd1, exp_n:1, exp_err:1'b1};

    // Reset values, asserted asynchronously with no clock edge involved.
    #3 reset_n = 1'b0;
    #1;
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_sum_en", sum_en, 0);
    check("rst_sum_done", sum_done, 0);
    check("rst_cmd_error", cmd_error, 0);
    check("rst_ready", instr_ready, 0);
    check("rst_cmd_count", cmd_count, 0);
    check("rst_busy_cycles", busy_cycles, 0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    check("ready_before_edge", instr_ready, 0);
    @(posedge clk);
    #1;
    check("ready_after_edge", instr_ready, 1);

    // Table: single commands, valid and dropped.
    for (int i = 0; i < 6; i++) begin
      epoch++;
      send(vecs[i].s, vecs[i].e, vecs[i].cs, vecs[i].ce, vecs[i].op, 1'b0);
      repeat (20) @(negedge clk);
      check($sformatf("v%0d_rd_count", i), rd_n, vecs[i].exp_n);
      check($sformatf("v%0d_wr_count", i), wr_n, vecs[i].exp_n);
      check($sformatf("v%0d_contig", i), contig_err, 0);
      check($sformatf("v%0d_wr_order", i), wr_mis, 0);
      check($sformatf("v%0d_cmd_error", i), cmd_error, vecs[i].exp_err);
      check($sformatf("v%0d_busy", i), busy, 0);
      if (vecs[i].exp_n > 0) begin
        check($sformatf("v%0d_rd_first", i), rd_first, vecs[i].s);
        check($sformatf("v%0d_rd_last", i), rd_last, vecs[i].e);
        check($sformatf("v%0d_wr_last", i), wr_last, vecs[i].e);
        check($sformatf("v%0d_wr_lag", i), wr_first_cyc - rd_first_cyc, LAT - 1);
        check($sformatf("v%0d_cmd_op", i), cmd_op, vecs[i].op);
        check($sformatf("v%0d_col_start", i), cmd_col_start, vecs[i].cs);
        check($sformatf("v%0d_col_end", i), cmd_col_end, vecs[i].ce);
      end
    end

    // Single last command 5..7, then the full sum sweep.
    do_reset();
    epoch++;
    send(12'd5, 12'd7, 12'd0, 12'd9, 2'd1, 1'b1);
    wait_sum_done(3000);
    check("one_rd_count", rd_n, 3);
    check("one_rd_first", rd_first, 5);
    check("one_rd_last", rd_last, 7);
    check("one_wr_count", wr_n, 3);
    check("one_wr_lag", wr_first_cyc - rd_first_cyc, LAT - 1);
    check("one_wr_order", wr_mis, 0);
    check("one_sum_count", sum_n, 1000);
    check("one_sum_first", sum_first, 0);
    check("one_sum_last", sum_last, 999);
    check("one_sum_contig", sum_contig, 0);
    check("one_wr_in_sum", wr_in_sum, 0);
    check("one_busy", busy, 0);
    check("one_ready_after_last", instr_ready, 0);
    repeat (5) @(negedge clk);
    check("one_sum_done_held", sum_done, 1);

    // Back-to-back commands fill the FIFO; a last command arrives mid-sweep.
    do_reset();
    epoch++;
    send(12'd20, 12'd29, 12'd1, 12'd2, 2'd0, 1'b0);
    send(12'd30, 12'd32, 12'd1, 12'd2, 2'd1, 1'b0);
    send(12'd40, 12'd41, 12'd1, 12'd2, 2'd2, 1'b0);
    send(12'd50, 12'd50, 12'd1, 12'd2, 2'd3, 1'b0);
    send(12'd60, 12'd63, 12'd1, 12'd2, 2'd0, 1'b0);
    check("fifo_full_ready", instr_ready, 0);
    send(12'd70, 12'd71, 12'd5, 12'd6, 2'd1, 1'b1);
    wait_sum_done(4000);
    check("q_rd_count", rd_n, 22);
    check("q_wr_count", wr_n, 22);
    check("q_wr_order", wr_mis, 0);
    check("q_no_overlap", gap_viol, 0);
    check("q_contig", contig_err, 0);
    check("q_burst_count", bursts.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < bursts.size()) check($sformatf("q_burst%0d_start", i), bursts[i], exp_bursts[i]);
    end
    check("q_sum_count", sum_n, 1000);
    check("q_wr_in_sum", wr_in_sum, 0);
    check("q_pending", pend.size(), 0);
    check("q_cmd_error", cmd_error, 0);

    // Reset during row 300 of a 0..999 sweep.
    do_reset();
    epoch++;
    send(12'd0, 12'd999, 12'd3, 12'd4, 2'd1, 1'b0);
    begin
      int k;
      k = 0;
      while (!(rd_en && rd_addr == 10'd300) && k < 2000) begin
        @(negedge clk);
        k++;
      end
      check("mid_row300_seen", rd_addr, 300);
    end
    #2 reset_n = 1'b0;
    #1;
    check("mid_rd_en", rd_en, 0);
    check("mid_wr_en", wr_en, 0);
    check("mid_rd_addr", rd_addr, 0);
    check("mid_busy", busy, 0);
    check("mid_cmd_op", cmd_op, 0);
    check("mid_ready", instr_ready, 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_ready_after", instr_ready, 1);
    epoch++;
    repeat (20) @(negedge clk);
    check("mid_no_rd", rd_n, 0);
    check("mid_no_wr", wr_n, 0);
    check("mid_idle", busy, 0);

    // Statistics: three single-row commands.
    do_reset();
    epoch++;
    send(12'd0, 12'd0, 12'd0, 12'd0, 2'd0, 1'b0);
    send(12'd0, 12'd0, 12'd0, 12'd0, 2'd0, 1'b0);
    send(12'd0, 12'd0, 12'd0, 12'd0, 2'd0, 1'b0);
    repeat (20) @(negedge clk);
    check("st_rd_count", rd_n, 3);
    check("st_busy_model", busy_n, 12);
`ifdef LIGHT_SWEEP_STATS_EN
    check("st_cmd_count", cmd_count, 3);
    check("st_busy_cycles", busy_cycles, busy_n);
`else
    check("st_cmd_count", cmd_count, 0);
    check("st_busy_cycles", busy_cycles, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
